alu_sweep_ctrl: RTL and testbench

ALU_SWEEP_CTRL -- requirements
Module: alu_sweep_ctrl

---
 rtl/alu_sweep_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_sweep_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_sweep_ctrl
// Purpose  : Latches two operands, sweeps an external ALU through add, sub,
//            and, or, and streams each (op, result) pair over a valid/ready
//            interface. Optional result self-check enabled by the macro
//            ALU_SWEEP_CHECK_EN (sticky err flag).
// Revision : 1.0 - initial release
// ============================================================================
module alu_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_op,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_OUT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] c_LAST_OP = 2'd3;

    state_t           r_state_q,     w_state_d;
    logic [WIDTH-1:0] r_alu_a_q,     w_alu_a_d;
    logic [WIDTH-1:0] r_alu_b_q,     w_alu_b_d;
    logic [1:0]       r_alu_op_q,    w_alu_op_d;
    logic [WIDTH-1:0] r_res_data_q,  w_res_data_d;
    logic [1:0]       r_res_op_q,    w_res_op_d;
    logic             r_res_valid_q, w_res_valid_d;
    logic             r_busy_q,      w_busy_d;
    logic             r_done_q,      w_done_d;

    always_comb begin
        w_state_d    = r_state_q;
        w_alu_a_d    = r_alu_a_q;
        w_alu_b_d    = r_alu_b_q;
        w_alu_op_d   = r_alu_op_q;
        w_res_data_d = r_res_data_q;
        w_res_op_d   = r_res_op_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_alu_a_d  = a_in;
                    w_alu_b_d  = b_in;
                    w_alu_op_d = 2'd0;
                    w_state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_res_data_d = alu_result;
                w_res_op_d   = r_alu_op_q;
                w_state_d    = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    if (r_res_op_q != c_LAST_OP) begin
                        w_alu_op_d = r_alu_op_q + 2'd1;
                        w_state_d  = S_DRIVE;
                    end else begin
                        w_state_d  = S_DONE;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
        // Status outputs are registered copies of the next state
        w_res_valid_d = (w_state_d == S_OUT);
        w_done_d      = (w_state_d == S_DONE);
        w_busy_d      = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_alu_a_q     <= '0;
            r_alu_b_q     <= '0;
            r_alu_op_q    <= 2'd0;
            r_res_data_q  <= '0;
            r_res_op_q    <= 2'd0;
            r_res_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_alu_a_q     <= w_alu_a_d;
            r_alu_b_q     <= w_alu_b_d;
            r_alu_op_q    <= w_alu_op_d;
            r_res_data_q  <= w_res_data_d;
            r_res_op_q    <= w_res_op_d;
            r_res_valid_q <= w_res_valid_d;
            r_busy_q      <= w_busy_d;
            r_done_q      <= w_done_d;
        end
    end

    assign alu_a     = r_alu_a_q;
    assign alu_b     = r_alu_b_q;
    assign alu_op    = r_alu_op_q;
    assign res_data  = r_res_data_q;
    assign res_op    = r_res_op_q;
    assign res_valid = r_res_valid_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;

`ifdef ALU_SWEEP_CHECK_EN
    logic [WIDTH-1:0] w_expect;
    logic             w_err_d;
    logic             r_err_q;

    always_comb begin
        case (r_alu_op_q)
            2'd0:    w_expect = r_alu_a_q + r_alu_b_q;
            2'd1:    w_expect = r_alu_a_q - r_alu_b_q;
            2'd2:    w_expect = r_alu_a_q & r_alu_b_q;
            default: w_expect = r_alu_a_q | r_alu_b_q;
        endcase
        w_err_d = r_err_q | ((r_state_q == S_DRIVE) && (alu_result != w_expect));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_q <= 1'b0;
        end else begin
            r_err_q <= w_err_d;
        end
    end

    assign err = r_err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sweep_ctrl
// Purpose  : Scoreboard bench for alu_sweep_ctrl with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sweep_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in, b_in;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             res_valid, res_ready;
    logic [1:0]       res_op;
    logic [WIDTH-1:0] res_data;
    logic             busy, done, err;
    logic             bad_alu;

    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    alu_sweep_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op),
        .res_data(res_data), .busy(busy), .done(done), .err(err)
    );

    // External ALU; bad_alu zeroes the AND result to exercise the checker
    always_comb begin
        case (alu_op)
            2'd0:    alu_result = alu_a + alu_b;
            2'd1:    alu_result = alu_a - alu_b;
            2'd2:    alu_result = bad_alu ? 4'b0000 : (alu_a & alu_b);
            default: alu_result = alu_a | alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result is compared against the head of the queue
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {26'd0, res_op, res_data}, 32'hFFFF_FFFF);
            end else begin
                check("result_op_data", {26'd0, res_op, res_data}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic push4(input logic [3:0] r0, input logic [3:0] r1,
                         input logic [3:0] r2, input logic [3:0] r3);
        exp_q.push_back({2'd0, r0});
        exp_q.push_back({2'd1, r1});
        exp_q.push_back({2'd2, r2});
        exp_q.push_back({2'd3, r3});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the accepting edge
    task automatic do_start(input logic [3:0] a, input logic [3:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        tick();
    endtask

    task automatic wait_res(input logic [1:0] op);
        int n = 0;
        while (!(res_valid && res_op == op) && n < 40) begin
            tick();
            n++;
        end
        check("res_op_seen", {30'd0, res_op}, {30'd0, op});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {28'd0, busy, done, res_valid, err}, 32'd0);
        check({tag, "_alu"},  {22'd0, alu_a, alu_b, alu_op}, 32'd0);
        check({tag, "_res"},  {26'd0, res_op, res_data}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        res_ready = 1'b1; bad_alu = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic sweep with cycle-accurate status pattern {busy,done,res_valid}
        push4(4'b1000, 4'b0010, 4'b0001, 4'b0111);
        do_start(4'b0101, 4'b0011);
        for (int j = 0; j <= 9; j++) begin
            logic [2:0] exp_st;
            exp_st[2] = (j <= 8);
            exp_st[1] = (j == 8);
            exp_st[0] = (j == 1 || j == 3 || j == 5 || j == 7);
            check("latency_status", {29'd0, busy, done, res_valid}, {29'd0, exp_st});
            tick();
        end
        check("alu_a_kept", {28'd0, alu_a}, 32'h5);
        check("alu_b_kept", {28'd0, alu_b}, 32'h3);

        // Subtraction wrap
        push4(4'b1000, 4'b1110, 4'b0001, 4'b0111);
        do_start(4'b0011, 4'b0101);
        wait_done();

        // Backpressure on the sub result
        push4(4'b1000, 4'b0010, 4'b0001, 4'b0111);
        do_start(4'b0101, 4'b0011);
        wait_res(2'd1);
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_hold", {25'd0, res_valid, res_op, res_data}, {25'd0, 1'b1, 2'd1, 4'b0010});
            tick();
        end
        res_ready = 1'b1;
        wait_done();

        // Start re-pulsed and operands changed mid-sweep
        push4(4'b1000, 4'b0010, 4'b0001, 4'b0111);
        do_start(4'b0101, 4'b0011);
        tick();
        a_in = 4'b1111; b_in = 4'b1111; start = 1'b1;
        tick();
        check("no_restart_alu_a", {28'd0, alu_a}, 32'h5);
        tick();
        start = 1'b0;
        wait_done();
        check("idle_after_sweep", {31'd0, busy}, 32'd0);
        check("alu_a_after_sweep", {28'd0, alu_a}, 32'h5);

        // Reset while presenting the AND result
        push4(4'b1000, 4'b0010, 4'b0001, 4'b0111);
        do_start(4'b0101, 4'b0011);
        wait_res(2'd2);
        rst = 1'b1; res_ready = 1'b0;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        exp_q.delete();
        res_ready = 1'b1;
        tick();
        push4(4'b0000, 4'b0100, 4'b0010, 4'b1110);
        do_start(4'b1010, 4'b0110);
        check("restart_op00", {30'd0, alu_op}, 32'd0);
        wait_done();

`ifdef ALU_SWEEP_CHECK_EN
        // Faulty ALU on the AND op must latch err until reset
        bad_alu = 1'b1;
        push4(4'b1101, 4'b0001, 4'b0000, 4'b0111);
        do_start(4'b0111, 4'b0110);
        wait_done();
        repeat (3) tick();
        check("err_sticky", {31'd0, err}, 32'd1);
        bad_alu = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        check("err_clear", {31'd0, err}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
